// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and types for the VGA timing generator.
package vga_timing_pkg;

  // 640x480 @ 60 Hz defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_phase_e;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus the phase FSM that tracks it.
// The phase only moves on the same step as the count, so the two can
// never disagree.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output coord_t     count,
  output vga_phase_e phase,
  output logic       wrap
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  // last count value of each phase
  localparam coord_t ACT_END  = coord_t'(ACTIVE_LEN - 1);
  localparam coord_t FP_END   = coord_t'(ACTIVE_LEN + FP_LEN - 1);
  localparam coord_t SYNC_END = coord_t'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam coord_t LAST     = coord_t'(TOTAL - 1);

  if (TOTAL > 1024 || ACTIVE_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_geom
    $error("vga_axis_counter: every phase needs >=1 count and the total must fit 10 bits");
  end

  // wrap is combinational so the next axis steps on the very same edge
  assign wrap = step && (count == LAST);

  // advance count and phase together on each step
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= ACTIVE;
    end else if (step) begin
      if (count == LAST) begin
        count <= '0;
        phase <= ACTIVE;
      end else begin
        count <= count + 1'b1;
        case (phase)
          ACTIVE:  if (count == ACT_END)  phase <= FRONT;
          FRONT:   if (count == FP_END)   phase <= SYNC;
          SYNC:    if (count == SYNC_END) phase <= BACK;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock divider, H/V axis counters and a
// registered output decode stage (DE, coordinates, syncs, start pulses).
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pclk,
  output logic        pix_tick,
  output logic        DE,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        h_sync,
  output logic        v_sync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt, div_nxt;
  coord_t        h_cnt, v_cnt;
  vga_phase_e    h_phase, v_phase;
  logic          h_wrap, v_wrap;
  logic          line_moved, frame_moved;

  // next divider value; pix_tick/pclk are registered copies of its decode
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // pixel-rate divider
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
      pclk     <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
      pclk     <= (div_nxt >= DIV_HALF);
    end
  end

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h (
    .clk   (clk),
    .reset (reset),
    .step  (pix_tick),
    .count (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v (
    .clk   (clk),
    .reset (reset),
    .step  (h_wrap),
    .count (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // remember that the counters just arrived at x=0 / (0,0); reset counts
  // as an arrival so the first decoded pixel also pulses both starts
  always_ff @(posedge clk) begin
    if (reset) begin
      line_moved  <= 1'b1;
      frame_moved <= 1'b1;
    end else begin
      line_moved  <= h_wrap;
      frame_moved <= v_wrap;
    end
  end

  // output decode, one clk behind the counters, all on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      DE          <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DE          <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      x_pixel     <= h_cnt;
      y_pixel     <= v_cnt;
      h_sync      <= (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      v_sync      <= (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
      line_start  <= line_moved;
      frame_start <= frame_moved;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // count frames; the increment lands together with frame_start
  always_ff @(posedge clk) begin
    if (reset)            frame_cnt <= '0;
    else if (frame_moved) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
